// File: rtl/xbus_arbiter_pkg.sv
// Shared XBus channel definitions: FSM state encoding, word width and index helpers.
package xbus_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StHold = 2'd1,
    StDone = 2'd2
  } xbus_state_e;

  localparam int unsigned XbusDataW = 11;

  // Round-robin pointer advance: idx+1, wrapping at n-1 -> 0.
  function automatic int unsigned wrap_inc(int unsigned idx, int unsigned n);
    if (idx + 1 >= n) begin
      return 0;
    end
    return idx + 1;
  endfunction

endpackage

// File: rtl/xbus_arbiter_rr_pick.sv
// Round-robin picker: first set request at or after ptr, wrapping at NUM_PORTS-1 -> 0.
module xbus_arbiter_rr_pick #(
  parameter int unsigned NUM_PORTS = 2,
  parameter int unsigned IDX_W     = 1
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]     ptr,
  output logic                 grant_valid,
  output logic [IDX_W-1:0]     grant_idx
);

  int unsigned idx;

  // Scan from the farthest offset down so the nearest request to ptr wins last.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      idx = (32'(ptr) + NUM_PORTS - 1 - k) % NUM_PORTS;
      if (req[idx[IDX_W-1:0]]) begin
        grant_valid = 1'b1;
        grant_idx   = idx[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/xbus_arbiter.sv
// XBus channel arbiter: pairs a held writer with a reader on another port and moves one word.
module xbus_arbiter
  import xbus_arbiter_pkg::*;
#(
  parameter int unsigned NUM_PORTS   = 2,
  parameter int unsigned DATA_W      = XbusDataW,
  parameter int unsigned STALL_TICKS = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        posedge_big_clk,
  input  logic [NUM_PORTS-1:0]        wr_req,
  input  logic [NUM_PORTS*DATA_W-1:0] wr_data,
  input  logic [NUM_PORTS-1:0]        rd_req,
  output logic [NUM_PORTS-1:0]        wr_done,
  output logic [NUM_PORTS-1:0]        rd_done,
  output logic [DATA_W-1:0]           rd_data,
  output logic [$clog2(NUM_PORTS)-1:0] bus_owner,
  output logic                        bus_busy,
  output logic                        stall
);

  localparam int unsigned IdxW  = $clog2(NUM_PORTS);
  localparam int unsigned TickW = $clog2(STALL_TICKS + 1);

  xbus_state_e         state_q, state_d;
  logic [DATA_W-1:0]    data_q, data_d;
  logic [IdxW-1:0]      owner_q, owner_d;
  logic                 busy_q, busy_d;
  logic                 stall_q, stall_d;
  logic [IdxW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [IdxW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [TickW-1:0]     tick_q, tick_d;
  logic [NUM_PORTS-1:0] wr_done_q, wr_done_d;
  logic [NUM_PORTS-1:0] rd_done_q, rd_done_d;
  logic [DATA_W-1:0]    rd_data_q, rd_data_d;

  logic [DATA_W-1:0]    wr_word [NUM_PORTS];
  logic [NUM_PORTS-1:0] owner_mask;
  logic [NUM_PORTS-1:0] rd_elig;
  logic [NUM_PORTS-1:0] rd_onehot;
  logic                 wr_gnt_valid, rd_gnt_valid;
  logic [IdxW-1:0]      wr_gnt_idx, rd_gnt_idx;

  always_comb begin
    owner_mask = '0;
    rd_onehot  = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      wr_word[i]    = wr_data[i*DATA_W +: DATA_W];
      owner_mask[i] = (owner_q == IdxW'(i));
      rd_onehot[i]  = (rd_gnt_idx == IdxW'(i));
    end
  end

  // A port can never read its own write.
  assign rd_elig = rd_req & ~owner_mask;

  xbus_arbiter_rr_pick #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IdxW)
  ) u_wr_pick (
    .req         (wr_req),
    .ptr         (wr_ptr_q),
    .grant_valid (wr_gnt_valid),
    .grant_idx   (wr_gnt_idx)
  );

  xbus_arbiter_rr_pick #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IdxW)
  ) u_rd_pick (
    .req         (rd_elig),
    .ptr         (rd_ptr_q),
    .grant_valid (rd_gnt_valid),
    .grant_idx   (rd_gnt_idx)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      data_q    <= '0;
      owner_q   <= '0;
      busy_q    <= 1'b0;
      stall_q   <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      tick_q    <= '0;
      wr_done_q <= '0;
      rd_done_q <= '0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      owner_q   <= owner_d;
      busy_q    <= busy_d;
      stall_q   <= stall_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      tick_q    <= tick_d;
      wr_done_q <= wr_done_d;
      rd_done_q <= rd_done_d;
      rd_data_q <= rd_data_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    owner_d   = owner_q;
    busy_d    = busy_q;
    stall_d   = stall_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    tick_d    = tick_q;
    wr_done_d = '0;
    rd_done_d = '0;
    rd_data_d = '0;
    unique case (state_q)
      StIdle: begin
        if (wr_gnt_valid) begin
          state_d  = StHold;
          data_d   = wr_word[wr_gnt_idx];
          owner_d  = wr_gnt_idx;
          busy_d   = 1'b1;
          wr_ptr_d = IdxW'(wrap_inc(32'(wr_gnt_idx), NUM_PORTS));
          tick_d   = '0;
        end
      end
      StHold: begin
        // Withdrawal wins over a same-cycle match.
        if (!wr_req[owner_q]) begin
          state_d = StIdle;
          busy_d  = 1'b0;
          stall_d = 1'b0;
          tick_d  = '0;
        end else if (rd_gnt_valid) begin
          state_d   = StDone;
          rd_ptr_d  = IdxW'(wrap_inc(32'(rd_gnt_idx), NUM_PORTS));
          rd_data_d = data_q;
          rd_done_d = rd_onehot;
          wr_done_d = owner_mask;
          stall_d   = 1'b0;
          tick_d    = '0;
        end else begin
          if (posedge_big_clk && (tick_q != TickW'(STALL_TICKS))) begin
            tick_d = tick_q + TickW'(1);
          end
          stall_d = (tick_d == TickW'(STALL_TICKS));
        end
      end
      StDone: begin
        state_d = StIdle;
        busy_d  = 1'b0;
        stall_d = 1'b0;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign wr_done   = wr_done_q;
  assign rd_done   = rd_done_q;
  assign rd_data   = rd_data_q;
  assign bus_owner = owner_q;
  assign bus_busy  = busy_q;
  assign stall     = stall_q;

endmodule

// File: tb/tb_xbus_arbiter.sv
// Self-checking bench for xbus_arbiter with a transaction-level reference model.
module tb_xbus_arbiter;
  import xbus_arbiter_pkg::*;

  localparam int N  = 3;
  localparam int DW = 11;
  localparam int ST = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            big = 1'b0;
  logic [N-1:0]    wr_req = '0;
  logic [N-1:0]    rd_req = '0;
  logic [N*DW-1:0] wr_data = '0;
  logic [N-1:0]    wr_done, rd_done;
  logic [DW-1:0]   rd_data;
  logic [1:0]      bus_owner;
  logic            bus_busy, stall;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  xbus_arbiter #(
    .NUM_PORTS   (N),
    .DATA_W      (DW),
    .STALL_TICKS (ST)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .posedge_big_clk (big),
    .wr_req          (wr_req),
    .wr_data         (wr_data),
    .rd_req          (rd_req),
    .wr_done         (wr_done),
    .rd_done         (rd_done),
    .rd_data         (rd_data),
    .bus_owner       (bus_owner),
    .bus_busy        (bus_busy),
    .stall           (stall)
  );

  // Reference model: phase 0 = channel free, 1 = write held, 2 = completing.
  int            m_phase, m_wptr, m_rptr, m_ticks, e_owner;
  logic [DW-1:0] m_data, e_rd_data;
  logic [N-1:0]  e_wr_done, e_rd_done;
  logic          e_busy, e_stall;

  always @(posedge clk) begin : model
    int w, r, idx;
    if (reset) begin
      m_phase = 0; m_wptr = 0; m_rptr = 0; m_ticks = 0; e_owner = 0; m_data = '0;
      e_wr_done = '0; e_rd_done = '0; e_rd_data = '0; e_busy = 1'b0; e_stall = 1'b0;
    end else begin
      e_wr_done = '0; e_rd_done = '0; e_rd_data = '0;
      if (m_phase == 0) begin
        w = -1;
        for (int k = N - 1; k >= 0; k--) begin
          idx = (m_wptr + k) % N;
          if (wr_req[idx]) w = idx;
        end
        if (w >= 0) begin
          m_data = wr_data[w*DW +: DW];
          e_owner = w; e_busy = 1'b1; m_wptr = (w + 1) % N; m_ticks = 0; m_phase = 1;
        end
      end else if (m_phase == 1) begin
        if (!wr_req[e_owner]) begin
          m_phase = 0; e_busy = 1'b0; e_stall = 1'b0;
        end else begin
          r = -1;
          for (int k = N - 1; k >= 0; k--) begin
            idx = (m_rptr + k) % N;
            if (rd_req[idx] && idx != e_owner) r = idx;
          end
          if (r >= 0) begin
            e_rd_done = N'(1) << r; e_wr_done = N'(1) << e_owner; e_rd_data = m_data;
            m_rptr = (r + 1) % N; e_stall = 1'b0; m_phase = 2;
          end else begin
            if (big && m_ticks < ST) m_ticks++;
            e_stall = (m_ticks == ST);
          end
        end
      end else begin
        e_busy = 1'b0; e_stall = 1'b0; m_phase = 0;
      end
    end
  end

  wire [20:0] dut_vec = {rd_done, wr_done, rd_data, bus_owner, bus_busy, stall};
  wire [20:0] exp_vec = {e_rd_done, e_wr_done, e_rd_data, 2'(e_owner), e_busy, e_stall};

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (dut_vec !== '0) begin
      errors++; $display("FAIL reset_init got %h want 0", dut_vec);
    end
    reset = 1'b0; wr_data = {3{11'd5}}; wr_req = 3'b001;
    @(negedge clk);
    checks++;
    if (bus_busy !== 1'b1 || dut_vec !== exp_vec) begin
      errors++; $display("FAIL reset_pre_hold got %h want %h", dut_vec, exp_vec);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; wr_req = '0;
    checks++;
    if (dut_vec !== '0) begin
      errors++; $display("FAIL reset_mid_hold got %h want 0", dut_vec);
    end
    @(negedge clk);
    checks++;
    if (dut_vec !== exp_vec || bus_busy !== 1'b0) begin
      errors++; $display("FAIL reset_after got %h want %h", dut_vec, exp_vec);
    end
  endtask

  task automatic test_single;
    wr_data[0 +: DW] = 11'd42; wr_req = 3'b001; rd_req = 3'b010;
    @(negedge clk);
    checks++;
    if (dut_vec !== exp_vec || rd_done !== 3'b000) begin
      errors++; $display("FAIL single_c1 got %h want %h", dut_vec, exp_vec);
    end
    @(negedge clk);
    checks++;
    if (rd_done !== 3'b010 || wr_done !== 3'b001 || rd_data !== 11'd42) begin
      errors++;
      $display("FAIL single_pulse got rd=%b wr=%b d=%0d want 010 001 42", rd_done, wr_done, rd_data);
    end
    wr_req = '0; rd_req = '0;
    @(negedge clk);
    checks++;
    if (rd_done !== '0 || wr_done !== '0 || rd_data !== '0 || bus_busy !== 1'b0) begin
      errors++; $display("FAIL single_after got %h want pulses cleared", dut_vec);
    end
  endtask

  task automatic test_stall;
    bit seen;
    wr_data[0 +: DW] = 11'h419; wr_req = 3'b001;
    @(negedge clk);
    for (int t = 1; t <= 5; t++) begin
      big = 1'b1;
      @(negedge clk);
      big = 1'b0;
      @(negedge clk);
      checks++;
      if (stall !== (t >= ST) || dut_vec !== exp_vec) begin
        errors++;
        $display("FAIL stall_tick%0d got stall=%b vec=%h want stall=%b vec=%h",
                 t, stall, dut_vec, (t >= ST), exp_vec);
      end
    end
    rd_req = 3'b010;
    seen = 1'b0;
    for (int c = 0; c < 5 && !seen; c++) begin
      @(negedge clk);
      if (rd_done !== '0) seen = 1'b1;
    end
    checks++;
    if (!seen || rd_done !== 3'b010 || rd_data !== 11'h419 || stall !== 1'b0) begin
      errors++;
      $display("FAIL stall_done got seen=%b rd=%b d=%h stall=%b want 1 010 419 0",
               seen, rd_done, rd_data, stall);
    end
    wr_req = '0; rd_req = '0;
    @(negedge clk);
  endtask

  task automatic test_rr;
    int seq[4];
    logic [DW-1:0] dat[4];
    int n = 0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    wr_data[0 +: DW] = 11'd100; wr_data[DW +: DW] = 11'h7fb; wr_req = 3'b011; rd_req = 3'b100;
    for (int c = 0; c < 60 && n < 4; c++) begin
      @(negedge clk);
      checks++;
      if (dut_vec !== exp_vec) begin
        errors++; $display("FAIL rr_model got %h want %h", dut_vec, exp_vec);
      end
      if (wr_done !== '0) begin
        seq[n] = (wr_done == 3'b001) ? 0 : (wr_done == 3'b010) ? 1 : 9;
        dat[n] = rd_data;
        n++;
      end
    end
    wr_req = '0; rd_req = '0;
    checks++;
    if (n != 4) begin
      errors++; $display("FAIL rr_count got %0d want 4", n);
    end
    for (int i = 0; i < n; i++) begin
      checks++;
      if (seq[i] != (i % 2) || dat[i] !== ((i % 2 == 0) ? 11'd100 : 11'h7fb)) begin
        errors++;
        $display("FAIL rr_grant%0d got port=%0d data=%h want port=%0d", i, seq[i], dat[i], i % 2);
      end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_own;
    wr_data[0 +: DW] = 11'd3; wr_req = 3'b001; rd_req = 3'b001;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      checks++;
      if ((wr_done | rd_done) !== '0 || dut_vec !== exp_vec) begin
        errors++; $display("FAIL own_only c%0d got %h want %h", c, dut_vec, exp_vec);
      end
    end
    wr_data[DW +: DW] = 11'd7; wr_req = 3'b011;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      checks++;
      if ((wr_done | rd_done) !== '0 || bus_owner !== 2'd0 || bus_busy !== 1'b1) begin
        errors++; $display("FAIL own_held c%0d got %h want owner 0 busy no pulses", c, dut_vec);
      end
    end
    wr_req = '0; rd_req = '0;
    @(negedge clk);
    checks++;
    if (bus_busy !== 1'b0 || dut_vec !== exp_vec) begin
      errors++; $display("FAIL own_release got %h want %h", dut_vec, exp_vec);
    end
  endtask

  task automatic test_withdraw;
    wr_data[0 +: DW] = 11'd9; wr_req = 3'b001;
    @(negedge clk);
    wr_req = '0; rd_req = 3'b010;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if ((wr_done | rd_done) !== '0 || bus_busy !== 1'b0 || dut_vec !== exp_vec) begin
        errors++; $display("FAIL withdraw c%0d got %h want idle", c, dut_vec);
      end
    end
    rd_req = '0;
    @(negedge clk);
  endtask

  task automatic test_random;
    int xfers = 0;
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 199) == 0);
      big   = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < N; i++) begin
        int v;
        if ($urandom_range(0, 3) == 0) wr_req[i] = ~wr_req[i];
        if ($urandom_range(0, 3) == 0) rd_req[i] = ~rd_req[i];
        v = int'($urandom_range(0, 1998)) - 999;
        wr_data[i*DW +: DW] = v[DW-1:0];
      end
      @(negedge clk);
      checks++;
      if (dut_vec !== exp_vec) begin
        errors++; $display("FAIL random c%0d got %h want %h", c, dut_vec, exp_vec);
      end
      if (rd_done !== '0) xfers++;
    end
    reset = 1'b0; wr_req = '0; rd_req = '0; big = 1'b0;
    checks++;
    if (xfers < 20) begin
      errors++; $display("FAIL random_xfers got %0d want >= 20", xfers);
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_stall();
    test_rr();
    test_own();
    test_withdraw();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
